// File: rtl/rwb_ctl.sv
// Register write-back controller: merges ALU results with queued load results onto RAM port A.
// ALU writes have priority; loads wait in an in-order FIFO and are squashed by younger ALU writes.
module rwb_ctl #(
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter int FAW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ena_i,
  input  logic          alu_stb_i,
  input  logic [AW-1:0] alu_adr_i,
  input  logic [DW-1:0] alu_dat_i,
  input  logic          lsu_stb_i,
  input  logic [AW-1:0] lsu_adr_i,
  input  logic [DW-1:0] lsu_dat_i,
  output logic          lsu_ack_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  output logic          wre_o,
  input  logic [AW-1:0] hzd_adr_i,
  output logic          hzd_o,
  output logic [FAW:0]  cnt_o
);

  localparam int DEPTH = 1 << FAW;

  logic [DEPTH-1:0] vld_r;
  logic [AW-1:0]    adr_r [DEPTH];
  logic [DW-1:0]    dat_r [DEPTH];
  logic [FAW:0]     wptr_r;
  logic [FAW:0]     rptr_r;
  logic [AW-1:0]    hold_adr_r;
  logic [DW-1:0]    hold_dat_r;

  logic [FAW-1:0]   head_s;
  logic [FAW-1:0]   tail_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             hit_s;

  // FIFO status and push/pop decisions
  always_comb begin
    head_s  = rptr_r[FAW-1:0];
    tail_s  = wptr_r[FAW-1:0];
    empty_s = (wptr_r == rptr_r);
    full_s  = ((wptr_r ^ rptr_r) == {1'b1, {FAW{1'b0}}});
    push_s  = ena_i & ~rst_i & lsu_stb_i & ~full_s;
    pop_s   = ena_i & ~rst_i & ~alu_stb_i & ~empty_s;
  end

  // Port A mux: ALU first, then FIFO head; idle cycles keep the last driven address/data
  always_comb begin
    adr_o = hold_adr_r;
    dat_o = hold_dat_r;
    wre_o = 1'b0;
    if (alu_stb_i) begin
      adr_o = alu_adr_i;
      dat_o = alu_dat_i;
      wre_o = ena_i & ~rst_i;
    end else if (!empty_s && vld_r[head_s]) begin
      adr_o = adr_r[head_s];
      dat_o = dat_r[head_s];
      wre_o = ena_i & ~rst_i;
    end else begin
      wre_o = 1'b0;
    end
  end

  // Hazard lookup over live entries, plus status outputs forced quiet during reset
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (vld_r[i] & (adr_r[i] == hzd_adr_i));
    end
    hzd_o     = hit_s & ~rst_i;
    lsu_ack_o = push_s;
    cnt_o     = rst_i ? {(FAW+1){1'b0}} : (wptr_r - rptr_r);
  end

  // FIFO state, squash of older same-register loads, and idle-value holding
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_r     <= {(FAW+1){1'b0}};
      rptr_r     <= {(FAW+1){1'b0}};
      vld_r      <= {DEPTH{1'b0}};
      hold_adr_r <= {AW{1'b0}};
      hold_dat_r <= {DW{1'b0}};
    end else begin
      hold_adr_r <= adr_o;
      hold_dat_r <= dat_o;
      if (ena_i) begin
        // The ALU result is younger than anything already queued for the same register
        for (int i = 0; i < DEPTH; i++) begin
          if (alu_stb_i && vld_r[i] && (adr_r[i] == alu_adr_i)) begin
            vld_r[i] <= 1'b0;
          end else begin
            vld_r[i] <= vld_r[i];
          end
        end
        if (pop_s) begin
          vld_r[head_s] <= 1'b0;
          rptr_r        <= rptr_r + (FAW+1)'(1);
        end else begin
          rptr_r <= rptr_r;
        end
        if (push_s) begin
          vld_r[tail_s] <= 1'b1;
          adr_r[tail_s] <= lsu_adr_i;
          dat_r[tail_s] <= lsu_dat_i;
          wptr_r        <= wptr_r + (FAW+1)'(1);
        end else begin
          wptr_r <= wptr_r;
        end
      end else begin
        wptr_r <= wptr_r;
        rptr_r <= rptr_r;
      end
    end
  end

endmodule

// File: tb/tb_rwb_ctl.sv
// Self-checking bench for rwb_ctl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_rwb_ctl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int FAW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_i, ena_i;
  logic          alu_stb_i, lsu_stb_i;
  logic [AW-1:0] alu_adr_i, lsu_adr_i, hzd_adr_i;
  logic [DW-1:0] alu_dat_i, lsu_dat_i;
  logic          lsu_ack_o, wre_o, hzd_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [FAW:0]  cnt_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] ref_ram [32];
  logic [DW-1:0] dut_ram [32];

  rwb_ctl #(.AW(AW), .DW(DW), .FAW(FAW)) dut (
    .clk_i(clk), .rst_i(rst_i), .ena_i(ena_i),
    .alu_stb_i(alu_stb_i), .alu_adr_i(alu_adr_i), .alu_dat_i(alu_dat_i),
    .lsu_stb_i(lsu_stb_i), .lsu_adr_i(lsu_adr_i), .lsu_dat_i(lsu_dat_i),
    .lsu_ack_o(lsu_ack_o), .adr_o(adr_o), .dat_o(dat_o), .wre_o(wre_o),
    .hzd_adr_i(hzd_adr_i), .hzd_o(hzd_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: expected outputs from the queue contents, then advance the queue
  always @(negedge clk) begin
    int            n;
    logic          e_ack, e_hzd, e_wre, pop;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    ent_t          e;
    if (wre_o === 1'b1) dut_ram[adr_o] = dat_o;
    if (rst_i) begin
      chk("rst_wre", wre_o, 0);
      chk("rst_ack", lsu_ack_o, 0);
      chk("rst_hzd", hzd_o, 0);
      chk("rst_cnt", cnt_o, 0);
      q.delete();
    end else begin
      n = q.size();
      e_ack = ena_i && lsu_stb_i && (n < DEPTH);
      e_hzd = 1'b0;
      foreach (q[i]) if (q[i].v && q[i].a == hzd_adr_i) e_hzd = 1'b1;
      pop = 1'b0;
      e_wre = 1'b0;
      e_adr = '0;
      e_dat = '0;
      if (alu_stb_i) begin
        e_wre = ena_i;
        e_adr = alu_adr_i;
        e_dat = alu_dat_i;
      end else if (n > 0) begin
        pop = ena_i;
        e_wre = ena_i && q[0].v;
        e_adr = q[0].a;
        e_dat = q[0].d;
      end
      chk("wre", wre_o, e_wre);
      chk("ack", lsu_ack_o, e_ack);
      chk("hzd", hzd_o, e_hzd);
      chk("cnt", cnt_o, n);
      if (e_wre) begin
        chk("adr", adr_o, e_adr);
        chk("dat", dat_o, e_dat);
      end
      if (ena_i) begin
        if (alu_stb_i) begin
          foreach (q[i]) if (q[i].a == alu_adr_i) q[i].v = 1'b0;
          ref_ram[alu_adr_i] = alu_dat_i;
        end else if (pop) begin
          e = q.pop_front();
          if (e.v) ref_ram[e.a] = e.d;
        end
        if (e_ack) q.push_back('{v: 1'b1, a: lsu_adr_i, d: lsu_dat_i});
      end
    end
  end

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_ram[i] = '0;
      dut_ram[i] = '0;
    end
    rst_i = 1; ena_i = 1;
    alu_stb_i = 1; alu_adr_i = 5'd3; alu_dat_i = 32'h1234;
    lsu_stb_i = 1; lsu_adr_i = 5'd1; lsu_dat_i = 32'h1;
    hzd_adr_i = 5'd0;
    smp;
    chk("t1_rst_wre", wre_o, 0);
    chk("t1_rst_ack", lsu_ack_o, 0);
    chk("t1_rst_cnt", cnt_o, 0);
    next_cyc;
    rst_i = 0; lsu_stb_i = 0;
    smp;
    chk("t1_alu_wre", wre_o, 1);
    chk("t1_alu_adr", adr_o, 3);
    chk("t1_alu_dat", dat_o, 32'h1234);

    // single load, earliest retirement
    next_cyc;
    alu_stb_i = 0; lsu_stb_i = 1; lsu_adr_i = 5'd5; lsu_dat_i = 32'hAAAA; hzd_adr_i = 5'd5;
    smp;
    chk("t2_ack", lsu_ack_o, 1);
    chk("t2_hzd0", hzd_o, 0);
    next_cyc;
    lsu_stb_i = 0;
    smp;
    chk("t2_wre", wre_o, 1);
    chk("t2_adr", adr_o, 5);
    chk("t2_dat", dat_o, 32'hAAAA);
    chk("t2_cnt1", cnt_o, 1);
    chk("t2_hzd1", hzd_o, 1);
    next_cyc;
    smp;
    chk("t2_cnt0", cnt_o, 0);
    chk("t2_hzd2", hzd_o, 0);

    // fill while ALU busy, fifth load refused, then in-order drain
    for (int i = 1; i <= 5; i++) begin
      next_cyc;
      alu_stb_i = 1; alu_adr_i = 5'd20; alu_dat_i = i;
      lsu_stb_i = 1; lsu_adr_i = i[4:0]; lsu_dat_i = 32'h100 + i;
      smp;
      chk("t3_ack", lsu_ack_o, (i < 5) ? 1 : 0);
      if (i == 5) chk("t3_full_cnt", cnt_o, 4);
    end
    next_cyc;
    alu_stb_i = 0; lsu_stb_i = 0;
    for (int i = 1; i <= 4; i++) begin
      smp;
      chk("t3_drain_wre", wre_o, 1);
      chk("t3_drain_adr", adr_o, i);
      chk("t3_drain_dat", dat_o, 32'h100 + i);
      next_cyc;
    end
    // continuous push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      lsu_stb_i = 1; lsu_adr_i = 5'($urandom_range(0, 31)); lsu_dat_i = $urandom;
      next_cyc;
    end
    lsu_stb_i = 0;
    repeat (3) next_cyc;

    // squash of a queued load by a younger ALU write
    lsu_stb_i = 1; lsu_adr_i = 5'd7; lsu_dat_i = 32'h1111;
    next_cyc;
    lsu_stb_i = 0; alu_stb_i = 1; alu_adr_i = 5'd7; alu_dat_i = 32'h2222; hzd_adr_i = 5'd7;
    smp;
    chk("t4_wre", wre_o, 1);
    chk("t4_dat", dat_o, 32'h2222);
    chk("t4_cnt", cnt_o, 1);
    next_cyc;
    alu_stb_i = 0;
    smp;
    chk("t4_sq_wre", wre_o, 0);
    chk("t4_sq_hzd", hzd_o, 0);
    chk("t4_sq_cnt", cnt_o, 1);
    next_cyc;
    smp;
    chk("t4_pop_cnt", cnt_o, 0);
    chk("t4_ram7", dut_ram[7], 32'h2222);

    // same-cycle ALU write and load push to one register: load survives
    next_cyc;
    alu_stb_i = 1; alu_adr_i = 5'd9; alu_dat_i = 32'h9999;
    lsu_stb_i = 1; lsu_adr_i = 5'd9; lsu_dat_i = 32'h5555;
    smp;
    chk("t5_ack", lsu_ack_o, 1);
    chk("t5_alu_dat", dat_o, 32'h9999);
    next_cyc;
    alu_stb_i = 0; lsu_stb_i = 0; hzd_adr_i = 5'd9;
    smp;
    chk("t5_ld_wre", wre_o, 1);
    chk("t5_ld_dat", dat_o, 32'h5555);
    next_cyc;
    smp;
    chk("t5_ram9", dut_ram[9], 32'h5555);

    // global stall with two queued loads
    for (int i = 0; i < 2; i++) begin
      next_cyc;
      alu_stb_i = 1; alu_adr_i = 5'd30; alu_dat_i = 32'h30;
      lsu_stb_i = 1; lsu_adr_i = 5'(10 + i); lsu_dat_i = 32'hB0 + i;
    end
    next_cyc;
    ena_i = 0;
    repeat (3) begin
      smp;
      chk("t6_stall_wre", wre_o, 0);
      chk("t6_stall_ack", lsu_ack_o, 0);
      chk("t6_stall_cnt", cnt_o, 2);
      next_cyc;
    end
    ena_i = 1; alu_stb_i = 0; lsu_stb_i = 0;
    smp;
    chk("t6_res_adr0", adr_o, 10);
    next_cyc;
    smp;
    chk("t6_res_adr1", adr_o, 11);
    chk("t6_res_dat1", dat_o, 32'hB1);
    next_cyc;

    // randomized traffic
    repeat (800) begin
      rst_i     = ($urandom_range(0, 63) == 0);
      ena_i     = ($urandom_range(0, 7) != 0);
      alu_stb_i = ($urandom_range(0, 2) == 0);
      alu_adr_i = 5'($urandom_range(0, 7));
      alu_dat_i = $urandom;
      lsu_stb_i = ($urandom_range(0, 1) == 0);
      lsu_adr_i = 5'($urandom_range(0, 7));
      lsu_dat_i = $urandom;
      hzd_adr_i = 5'($urandom_range(0, 7));
      next_cyc;
    end
    rst_i = 0; ena_i = 1; alu_stb_i = 0; lsu_stb_i = 0;
    repeat (6) next_cyc;
    for (int i = 0; i < 32; i++) chk("ram_final", dut_ram[i], ref_ram[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rwb_ctl.md
Name: rwb_ctl

Overview:
- Register write-back controller feeding the read/write port A of the dual-port register RAM (adr_i/dat_i/wre_i).
- Merges two write-back sources:
  - ALU results: single-cycle, always accepted, highest priority.
  - Load (LSU) results: may arrive unaligned to RAM port availability; buffered in a small in-order FIFO.
- Supplies a hazard flag so decode can stall on registers with loads still pending.

Parameters:
- AW, 5, register address width (1<<AW registers).
- DW, 32, register data width.
- FAW, 2, FIFO address width; depth = 1<<FAW (4).

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ena_i  in  1  pipeline enable; low = global stall.
- alu_stb_i  in  1  ALU write-back request.
- alu_adr_i  in  AW  ALU destination register.
- alu_dat_i  in  DW  ALU result.
- lsu_stb_i  in  1  load write-back request.
- lsu_adr_i  in  AW  load destination register.
- lsu_dat_i  in  DW  load data.
- lsu_ack_o  out  1  load request accepted this cycle.
- adr_o  out  AW  to RAM port A address.
- dat_o  out  DW  to RAM port A write data.
- wre_o  out  1  to RAM port A write enable.
- hzd_adr_i  in  AW  register queried by decode.
- hzd_o  out  1  a valid FIFO entry targets hzd_adr_i.
- cnt_o  out  FAW+1  FIFO occupancy, including squashed entries not yet popped.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - Read/write pointers and count cleared to 0; all entry valid bits cleared.
  - While rst_i=1: wre_o=0, lsu_ack_o=0, hzd_o=0, cnt_o=0.
  - Reset mid-operation discards all queued loads; no write is issued.
- ena_i=0: no state change, wre_o=0, lsu_ack_o=0; hzd_o and cnt_o still reflect current contents.
- FIFO storage: each entry holds {valid, adr, dat}. The pointers are FAW+1 bits wide so full and empty are unambiguous.
- Push rule:
  - lsu_ack_o = ena_i & ~rst_i & lsu_stb_i & (cnt_o < depth).
  - No push when full, even if a pop occurs in the same cycle.
  - Pushed entry is written with valid=1.
- Port A mux (combinational):
  - If alu_stb_i: adr_o/dat_o = alu_adr_i/alu_dat_i; wre_o=ena_i.
  - Else if FIFO non-empty and head valid: head adr/dat; wre_o=ena_i; head popped at the edge.
  - Else if FIFO non-empty and head invalid (squashed): wre_o=0; head popped at the edge.
  - Else: wre_o=0. adr_o/dat_o hold the last driven values (don't-care, but must not be X after reset).
- Latency: a load accepted at cycle N can reach the RAM at cycle N+1 at the earliest (registered in FIFO). ALU writes reach the RAM in the same cycle.
- Squash (write-after-write ordering):
  - When ena_i & alu_stb_i, every valid FIFO entry (before this cycle's push) with adr == alu_adr_i is cleared to valid=0, because the ALU write is younger.
  - An LSU entry pushed in the same cycle is younger and is not squashed.
  - Squashed entries still occupy a slot until popped.
- Loads with the same address are all kept and retire in FIFO order.
- Simultaneous push and pop: count unchanged; both pointers advance.
- hzd_o: combinational OR over valid entries of (adr == hzd_adr_i). It does not include the entry being pushed in the current cycle.
- Pointer wrap: modulo 2·depth; full = (wptr^rptr) == {1'b1, FAW zeros}.

Test Plan:
- Reset with alu_stb_i=1, lsu_stb_i=1 -> wre_o=0, lsu_ack_o=0, cnt_o=0; after release, first cycle with an ALU write to r3=0x1234 gives wre_o=1, adr_o=3, dat_o=0x1234.
- Load r5=0xAAAA at cycle 0, ALU idle -> ack at 0; cycle 1: wre_o=1, adr_o=5, dat_o=0xAAAA, cnt_o 1->0; hzd_o(hzd_adr_i=5)=1 during cycle 1 only.
- Push 4 loads r1..r4 while the ALU writes every cycle -> cnt_o=4, 5th lsu_stb_i gets lsu_ack_o=0. ALU then idles -> r1..r4 written on 4 consecutive cycles in order. Wrap check: push/pop continuously for 20 cycles with data intact.
- Queue load r7=0x1111, then same cycle as drain opportunity ALU writes r7=0x2222 -> ALU write issued; entry squashed, hzd_o(7)=0; next cycle wre_o=0 with pop; RAM keeps 0x2222.
- Same cycle: ALU writes r9 and a load to r9 is pushed -> load not squashed; r9 ends at the load value.
- ena_i=0 for 3 cycles with 2 queued loads and alu_stb_i=1 -> wre_o=0, lsu_ack_o=0, cnt_o stays 2; after ena_i=1 normal draining resumes.
